// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Provides the run/idle state enum, the minimum ratio and the ratio clamp.
package clk_div_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam int unsigned MIN_DIV = 2;

    // Ratios below MIN_DIV cannot form a high and a low phase.
    function automatic int unsigned clamp_div(input int unsigned d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/clk_div_neg_stage.sv
// Falling-edge re-register of the divider high phase (odd-ratio 50% duty).
// Ports: clk, rst (async active-low), d (posedge high phase), q (delayed by 1/2 clk).
// Only built when CLK_DIV_DUTY50_EN is defined.
`ifdef CLK_DIV_DUTY50_EN
module clk_div_neg_stage (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) q <= 1'b0;
        else      q <= d;
    end

endmodule
`endif

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: runtime reload, clean stop, period tick.
// Ports: clk, rst (async active-low), en, load, div[CNT_W] -> out_clk, tick,
// ratio[CNT_W], busy. Macro CLK_DIV_DUTY50_EN adds 50% duty for odd ratios.
import clk_div_pkg::*;

module clk_div_prog #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned RESET_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    output logic             out_clk,
    output logic             tick,
    output logic [CNT_W-1:0] ratio,
    output logic             busy
);

    localparam logic [CNT_W-1:0] RST_RATIO = CNT_W'(clamp_div(RESET_DIV));

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             pos_q, pos_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] div_c;
    logic [CNT_W-1:0] cnt_inc;
    logic             wrap;

    assign div_c   = CNT_W'(clamp_div(32'(div)));
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign wrap    = (cnt_q == ratio_q - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        pos_d   = 1'b0;
        tick_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (busy_q) ratio_d = pend_q;
                busy_d = 1'b0;
                if (load) begin
                    pend_d = div_c;
                    busy_d = 1'b1;
                end
                if (en) begin
                    state_d = RUN;
                    pos_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    // A load in the wrap cycle takes effect at this wrap.
                    if (load) begin
                        ratio_d = div_c;
                        busy_d  = 1'b0;
                    end else if (busy_q) begin
                        ratio_d = pend_q;
                        busy_d  = 1'b0;
                    end
                    cnt_d = '0;
                    if (en) begin
                        pos_d  = 1'b1;
                        tick_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    pos_d = (cnt_inc < (ratio_q >> 1));
                    if (load) begin
                        pend_d = div_c;
                        busy_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ratio_q <= RST_RATIO;
            pend_q  <= RST_RATIO;
            busy_q  <= 1'b0;
            pos_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            pos_q   <= pos_d;
            tick_q  <= tick_d;
        end
    end

`ifdef CLK_DIV_DUTY50_EN
    logic neg_q;

    clk_div_neg_stage u_neg (
        .clk (clk),
        .rst (rst),
        .d   (pos_q),
        .q   (neg_q)
    );

    // Odd ratios stretch the high phase by half a clk via the negedge copy.
    assign out_clk = ratio_q[0] ? (pos_q | neg_q) : pos_q;
`else
    assign out_clk = pos_q;
`endif

    assign tick  = tick_q;
    assign ratio = ratio_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog (RESET_DIV=4).
// Per-cycle model comparison plus directed literal checks.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       load = 1'b0;
    logic [7:0] div = 8'd0;
    logic       out_clk;
    logic       tick;
    logic [7:0] ratio;
    logic       busy;

    int errs = 0;
    int checks = 0;

    clk_div_prog #(.CNT_W(8), .RESET_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .div     (div),
        .out_clk (out_clk),
        .tick    (tick),
        .ratio   (ratio),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: position in period, active ratio, pending ratio.
    bit m_run = 0;
    int m_ph = 0;
    int m_n = 4;
    int m_pend = 4;
    bit m_pv = 0;
    bit m_hi = 0;
    bit m_prev = 0;
    bit m_tick = 0;

    initial begin
        bit e, l;
        int dc;
        forever begin
            @(posedge clk);
            e = en;
            l = load;
            dc = (int'(div) < 2) ? 2 : int'(div);
            if (!rst) begin
                m_run = 0; m_ph = 0; m_n = 4;
                m_pv = 0; m_hi = 0; m_prev = 0;
                m_tick = 0;
            end else begin
                m_prev = m_hi;
                if (!m_run) begin
                    if (m_pv) m_n = m_pend;
                    m_pv = 0;
                    if (l) begin m_pend = dc; m_pv = 1; end
                    m_ph = 0;
                    m_run = e;
                end else if (m_ph == m_n - 1) begin
                    if (l) begin m_n = dc; m_pv = 0; end
                    else if (m_pv) begin m_n = m_pend; m_pv = 0; end
                    m_ph = 0;
                    m_run = e;
                end else begin
                    m_ph++;
                    if (l) begin m_pend = dc; m_pv = 1; end
                end
                m_tick = m_run && (m_ph == 0);
                m_hi = m_run && (2 * m_ph + 1 < m_n);
            end
            #1;
`ifdef CLK_DIV_DUTY50_EN
            chk("out_clk", int'(out_clk),
                int'(m_hi | ((m_n % 2 == 1) & m_prev)));
`else
            chk("out_clk", int'(out_clk), int'(m_hi));
`endif
            chk("tick", int'(tick), int'(m_tick));
            chk("ratio", int'(ratio), m_n);
            chk("busy", int'(busy), int'(m_pv));
        end
    end

    task automatic measure(output int hi, output int per, output int r);
        bit ok;
        hi = 0; per = 0; r = 0; ok = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(posedge clk); #1;
            if (tick) ok = 1;
        end
        if (!ok) begin
            chk("tick_timeout", 0, 1);
            return;
        end
        r = int'(ratio);
        hi = int'(out_clk);
        per = 1;
        ok = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(posedge clk); #1;
            if (tick) ok = 1;
            else begin
                per++;
                hi += int'(out_clk);
            end
        end
        if (!ok) chk("period_timeout", 0, 1);
    endtask

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        load = 1'b1;
        div = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int hi, per, r, bc, cnt_t;
        logic [7:0] pat, tpat;
        bit seen;

        // Reset state, then start with en already high.
        repeat (2) @(negedge clk);
        chk("rst_out", int'(out_clk), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ratio", int'(ratio), 4);
        rst = 1'b1;
        pat = '0;
        tpat = '0;
        repeat (8) begin
            @(posedge clk); #1;
            pat = {pat[6:0], out_clk};
            tpat = {tpat[6:0], tick};
        end
        chk("pat4", int'(pat), int'(8'b1100_1100));
        chk("tick4", int'(tpat), int'(8'b1000_1000));

        // Odd ratio 5.
        do_load(8'd5);
        measure(hi, per, r);
        chk("n5_ratio", r, 5);
        chk("n5_per", per, 5);
`ifdef CLK_DIV_DUTY50_EN
        chk("n5_hi", hi, 3);
`else
        chk("n5_hi", hi, 2);
`endif

        // Back to 4, then load 6 in the cnt=0 cycle.
        do_load(8'd4);
        measure(hi, per, r);
        chk("n4_per", per, 4);
        @(negedge clk);
        load = 1'b1;
        div = 8'd6;
        @(negedge clk);
        load = 1'b0;
        bc = int'(busy);
        seen = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (busy) bc++;
            else if (!seen) begin
                seen = 1;
                chk("n6_tick_at_apply", int'(tick), 1);
                chk("n6_ratio_at_apply", int'(ratio), 6);
            end
        end
        chk("n6_busy_cycles", bc, 3);
        measure(hi, per, r);
        chk("n6_per", per, 6);
        chk("n6_hi", hi, 3);

        // Drop en at cnt=1 of an N=8 period.
        do_load(8'd8);
        measure(hi, per, r);
        chk("n8_ratio", r, 8);
        chk("n8_per", per, 8);
        chk("n8_hi", hi, 4);
        hi = int'(out_clk);
        @(posedge clk); #1;
        hi += int'(out_clk);
        @(negedge clk);
        en = 1'b0;
        cnt_t = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            hi += int'(out_clk);
            cnt_t += int'(tick);
        end
        chk("stop_hi", hi, 4);
        chk("stop_ticks", cnt_t, 0);
        chk("stop_out", int'(out_clk), 0);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        chk("restart_tick", int'(tick), 1);
        chk("restart_out", int'(out_clk), 1);

        // Clamped ratios.
        do_load(8'd0);
        measure(hi, per, r);
        chk("d0_ratio", r, 2);
        chk("d0_per", per, 2);
        chk("d0_hi", hi, 1);
        do_load(8'd1);
        measure(hi, per, r);
        chk("d1_ratio", r, 2);
        chk("d1_per", per, 2);

        // Reset mid-period with a pending ratio.
        @(negedge clk);
        load = 1'b1;
        div = 8'd7;
        @(negedge clk);
        load = 1'b0;
        chk("pre_rst_busy", int'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_out", int'(out_clk), 0);
        chk("midrst_tick", int'(tick), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ratio", int'(ratio), 4);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        measure(hi, per, r);
        chk("post_rst_ratio", r, 4);
        chk("post_rst_per", per, 4);
        chk("post_rst_hi", hi, 2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
